// File: rtl/dma_seq_pkg.sv
// dma_seq_pkg
//   Shared types and constants for the DMA job sequencer.
//   - state_t      : issue state machine encoding
//   - ST_*         : completion status codes returned with each job
//   - DIR_*        : shim transfer direction encoding
//   - JOB_ADDR_W / JOB_LEN_W / job_width() : packed job record {id,len,dst,src}
package dma_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MM2S_ISSUE,
    MM2S_WAIT,
    S2MM_ISSUE,
    S2MM_WAIT,
    CMPL
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;

  localparam logic DIR_MM2S = 1'b1;
  localparam logic DIR_S2MM = 1'b0;

  localparam int JOB_ADDR_W = 32;
  localparam int JOB_LEN_W  = 30;

  // Width of one packed job record {id, len, dst, src}.
  function automatic int job_width(input int id_w);
    return id_w + JOB_LEN_W + 2 * JOB_ADDR_W;
  endfunction

endpackage

// File: rtl/dma_job_fifo.sv
// dma_job_fifo
//   Synchronous FIFO with power-of-two depth. Holds packed job records.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (empties FIFO)
//     push, wdata     : write request and record
//     pop, rdata      : read request; rdata shows the head entry (show-ahead)
//     full, empty     : occupancy flags
//     count           : current occupancy, 0..DEPTH
//   A push together with a pop is accepted even when full.
module dma_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/dma_job_sequencer.sv
// dma_job_sequencer
//   Queues memory-to-memory copy jobs and runs each one through the AXI DMA
//   shim as an MM2S transfer followed by an S2MM transfer, then returns one
//   completion record (id, status) per job in acceptance order.
//   Ports:
//     clk, reset                       : clock, synchronous active-high reset
//     job_valid/job_ready, job_*       : job input handshake and fields
//     cmp_valid/cmp_ready, cmp_id/status: completion record handshake
//     dma_start_transfer, dma_direction,
//     dma_ddr_addr, dma_length_bytes   : command to the shim (pulse + held fields)
//     dma_transfer_done                : shim done level, sticky until next start
//     busy, jobs_pending               : FSM not idle, FIFO occupancy
//   Optional build macro DMA_SEQ_TIMEOUT_EN adds a per-phase watchdog of
//   TIMEOUT_CYCLES wait cycles that completes the job with ST_TIMEOUT.
module dma_job_sequencer
  import dma_seq_pkg::*;
#(
  parameter int JOB_DEPTH      = 4,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [31:0]                   job_src_addr,
  input  logic [31:0]                   job_dst_addr,
  input  logic [29:0]                   job_length,
  input  logic [ID_WIDTH-1:0]           job_id,
  output logic                          cmp_valid,
  input  logic                          cmp_ready,
  output logic [ID_WIDTH-1:0]           cmp_id,
  output logic [1:0]                    cmp_status,
  output logic                          dma_start_transfer,
  output logic                          dma_direction,
  output logic [31:0]                   dma_ddr_addr,
  output logic [29:0]                   dma_length_bytes,
  input  logic                          dma_transfer_done,
  output logic                          busy,
  output logic [$clog2(JOB_DEPTH):0]    jobs_pending
);

  localparam int JOB_W = job_width(ID_WIDTH);

  logic [JOB_W-1:0]      fifo_wdata;
  logic [JOB_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  logic [JOB_ADDR_W-1:0] cur_src;
  logic [JOB_ADDR_W-1:0] cur_dst;
  logic [JOB_LEN_W-1:0]  cur_len;
  logic [ID_WIDTH-1:0]   cur_id;

  state_t                state;
  state_t                state_nx;
  logic                  load_cmp;
  logic                  load_mm2s;
  logic                  load_s2mm;
  logic [1:0]            status_nx;

  logic                  done_d;
  logic                  done_rise;
  logic                  timeout;

  assign job_ready  = !fifo_full;
  assign fifo_wdata = {job_id, job_length, job_dst_addr, job_src_addr};

  dma_job_fifo #(
    .DEPTH (JOB_DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (job_valid && job_ready),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (jobs_pending)
  );

  // Job being worked on; pure data, loaded on pop.
  always_ff @(posedge clk) begin
    if (fifo_pop) {cur_id, cur_len, cur_dst, cur_src} <= fifo_rdata;
  end

  // The shim's done level stays high from the previous transfer until the
  // next start, so only a rising edge counts as completion.
  always_ff @(posedge clk) begin
    done_d <= dma_transfer_done;
  end
  assign done_rise = dma_transfer_done && !done_d;

`ifdef DMA_SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Cleared in the ISSUE cycle so it reads 0 on the first WAIT cycle;
  // fires on the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == MM2S_ISSUE || state == S2MM_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == MM2S_WAIT || state == S2MM_WAIT) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
  assign timeout = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    fifo_pop  = 1'b0;
    load_cmp  = 1'b0;
    load_mm2s = 1'b0;
    load_s2mm = 1'b0;
    status_nx = ST_OK;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (cur_len == '0) begin
          state_nx  = CMPL;
          load_cmp  = 1'b1;
          status_nx = ST_REJECT;
        end else begin
          state_nx  = MM2S_ISSUE;
          load_mm2s = 1'b1;
        end
      end
      MM2S_ISSUE: state_nx = MM2S_WAIT;
      MM2S_WAIT: begin
        if (done_rise) begin
          state_nx  = S2MM_ISSUE;
          load_s2mm = 1'b1;
        end else if (timeout) begin
          state_nx  = CMPL;
          load_cmp  = 1'b1;
          status_nx = ST_TIMEOUT;
        end
      end
      S2MM_ISSUE: state_nx = S2MM_WAIT;
      S2MM_WAIT: begin
        if (done_rise) begin
          state_nx  = CMPL;
          load_cmp  = 1'b1;
          status_nx = ST_OK;
        end else if (timeout) begin
          state_nx  = CMPL;
          load_cmp  = 1'b1;
          status_nx = ST_TIMEOUT;
        end
      end
      CMPL: begin
        if (cmp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shim command fields are loaded on entry to each ISSUE state and held
  // until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cmp_id           <= '0;
      cmp_status       <= ST_OK;
      dma_direction    <= DIR_S2MM;
      dma_ddr_addr     <= '0;
      dma_length_bytes <= '0;
    end else begin
      state <= state_nx;
      if (load_cmp) begin
        cmp_id     <= cur_id;
        cmp_status <= status_nx;
      end
      if (load_mm2s) begin
        dma_direction    <= DIR_MM2S;
        dma_ddr_addr     <= cur_src;
        dma_length_bytes <= cur_len;
      end
      if (load_s2mm) begin
        dma_direction    <= DIR_S2MM;
        dma_ddr_addr     <= cur_dst;
        dma_length_bytes <= cur_len;
      end
    end
  end

  assign dma_start_transfer = (state == MM2S_ISSUE) || (state == S2MM_ISSUE);
  assign cmp_valid          = (state == CMPL);
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_dma_job_sequencer.sv
// tb_dma_job_sequencer
//   Bench for dma_job_sequencer with a reactive shim model. Build with
//   +define+DMA_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=100).
module tb_dma_job_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_src_addr = '0;
  logic [31:0] job_dst_addr = '0;
  logic [29:0] job_length = '0;
  logic [7:0]  job_id = '0;
  logic        cmp_valid;
  logic        cmp_ready = 1'b1;
  logic [7:0]  cmp_id;
  logic [1:0]  cmp_status;
  logic        dma_start_transfer;
  logic        dma_direction;
  logic [31:0] dma_ddr_addr;
  logic [29:0] dma_length_bytes;
  logic        dma_transfer_done = 1'b0;
  logic        busy;
  logic [2:0]  jobs_pending;

  dma_job_sequencer #(
    .JOB_DEPTH      (4),
    .ID_WIDTH       (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .job_valid          (job_valid),
    .job_ready          (job_ready),
    .job_src_addr       (job_src_addr),
    .job_dst_addr       (job_dst_addr),
    .job_length         (job_length),
    .job_id             (job_id),
    .cmp_valid          (cmp_valid),
    .cmp_ready          (cmp_ready),
    .cmp_id             (cmp_id),
    .cmp_status         (cmp_status),
    .dma_start_transfer (dma_start_transfer),
    .dma_direction      (dma_direction),
    .dma_ddr_addr       (dma_ddr_addr),
    .dma_length_bytes   (dma_length_bytes),
    .dma_transfer_done  (dma_transfer_done),
    .busy               (busy),
    .jobs_pending       (jobs_pending)
  );

  always #5 clk = ~clk;

  typedef struct {logic dir; logic [31:0] addr; logic [29:0] len; int cyc;} pulse_t;
  typedef struct {logic [7:0] id; logic [1:0] st; int cyc;} cmp_t;
  typedef struct {logic [31:0] src; logic [31:0] dst; logic [29:0] len; logic [7:0] id; int cyc;} job_t;

  pulse_t pulses[$];
  cmp_t   cmps[$];
  job_t   jobs[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic acc     = 1'b0;

  // Shim model: done falls after a start and rises shim_delay cycles after it.
  int   shim_delay = 20;
  int   shim_cnt   = 0;
  logic shim_busy  = 1'b0;
  logic shim_stall = 1'b0;

  task automatic clear_logs();
    pulses.delete();
    cmps.delete();
    jobs.delete();
  endtask

  task automatic tick();
    logic st;
    st = dma_start_transfer;
    if (dma_start_transfer)
      pulses.push_back('{dma_direction, dma_ddr_addr, dma_length_bytes, cyc});
    if (cmp_valid && cmp_ready)
      cmps.push_back('{cmp_id, cmp_status, cyc});
    acc = job_valid && job_ready;
    if (acc)
      jobs.push_back('{job_src_addr, job_dst_addr, job_length, job_id, cyc});
    @(posedge clk);
    #1;
    cyc++;
    if (st) begin
      shim_cnt  = shim_delay - 1;
      shim_busy = (shim_cnt != 0);
      dma_transfer_done = (shim_cnt == 0);
    end else if (shim_busy && !shim_stall) begin
      shim_cnt--;
      if (shim_cnt == 0) begin
        dma_transfer_done = 1'b1;
        shim_busy = 1'b0;
      end
    end
  endtask

  task automatic send_job(input logic [31:0] s, input logic [31:0] d,
                          input logic [29:0] l, input logic [7:0] id);
    logic got;
    got = 1'b0;
    job_src_addr = s; job_dst_addr = d; job_length = l; job_id = id;
    job_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (acc) begin got = 1'b1; break; end
    end
    job_valid = 1'b0;
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL job_accept id=%0h got accepted=%b want 1", id, got);
    end
  endtask

  task automatic drain(input int n, input int budget);
    int k;
    k = 0;
    while (cmps.size() < n && k < budget) begin tick(); k++; end
    n_tests++;
    if (cmps.size() < n) begin
      n_fail++;
      $display("FAIL drain got %0d completions want %0d", cmps.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready got %b want 1", job_ready); end
    n_tests++; if (cmp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_valid got %b want 0", cmp_valid); end
    n_tests++; if (cmp_id !== 8'h00) begin n_fail++; $display("FAIL reset_cmp_id got %h want 00", cmp_id); end
    n_tests++; if (cmp_status !== 2'b00) begin n_fail++; $display("FAIL reset_cmp_status got %b want 00", cmp_status); end
    n_tests++; if (dma_start_transfer !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", dma_start_transfer); end
    n_tests++; if (dma_direction !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", dma_direction); end
    n_tests++; if (dma_ddr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", dma_ddr_addr); end
    n_tests++; if (dma_length_bytes !== 30'h0) begin n_fail++; $display("FAIL reset_len got %h want 0", dma_length_bytes); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (jobs_pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", jobs_pending); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    clear_logs();
    shim_delay = 20; cmp_ready = 1'b1;
    send_job(32'h1000_0000, 32'h1100_0000, 30'd256, 8'h5A);
    drain(1, 300);
    n_tests++;
    if (pulses.size() !== 2) begin
      n_fail++; $display("FAIL single_pulse_count got %0d want 2", pulses.size());
    end else begin
      n_tests++;
      if (pulses[0].cyc !== jobs[0].cyc + 3) begin
        n_fail++; $display("FAIL single_first_latency got %0d want %0d", pulses[0].cyc - jobs[0].cyc, 3);
      end
      n_tests++;
      if ({pulses[0].dir, pulses[0].addr, pulses[0].len} !== {1'b1, 32'h1000_0000, 30'd256}) begin
        n_fail++; $display("FAIL single_mm2s got dir=%b addr=%h len=%0d want 1 10000000 256",
                           pulses[0].dir, pulses[0].addr, pulses[0].len);
      end
      n_tests++;
      if ({pulses[1].dir, pulses[1].addr, pulses[1].len} !== {1'b0, 32'h1100_0000, 30'd256}) begin
        n_fail++; $display("FAIL single_s2mm got dir=%b addr=%h len=%0d want 0 11000000 256",
                           pulses[1].dir, pulses[1].addr, pulses[1].len);
      end
      n_tests++;
      if (pulses[1].cyc !== pulses[0].cyc + 21) begin
        n_fail++; $display("FAIL single_s2mm_latency got %0d want 21", pulses[1].cyc - pulses[0].cyc);
      end
      if (cmps.size() > 0) begin
        n_tests++;
        if ({cmps[0].id, cmps[0].st} !== {8'h5A, 2'b00}) begin
          n_fail++; $display("FAIL single_cmp got id=%h st=%b want 5a 00", cmps[0].id, cmps[0].st);
        end
        n_tests++;
        if (cmps[0].cyc !== pulses[1].cyc + 21) begin
          n_fail++; $display("FAIL single_cmp_latency got %0d want 21", cmps[0].cyc - pulses[1].cyc);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    clear_logs();
    send_job(32'h3000_0000, 32'h3100_0000, 30'd0, 8'h03);
    drain(1, 50);
    n_tests++;
    if (pulses.size() !== 0) begin n_fail++; $display("FAIL zero_pulses got %0d want 0", pulses.size()); end
    if (cmps.size() > 0) begin
      n_tests++;
      if ({cmps[0].id, cmps[0].st} !== {8'h03, 2'b10}) begin
        n_fail++; $display("FAIL zero_cmp got id=%h st=%b want 03 10", cmps[0].id, cmps[0].st);
      end
      n_tests++;
      if (cmps[0].cyc !== jobs[0].cyc + 3) begin
        n_fail++; $display("FAIL zero_latency got %0d want 3", cmps[0].cyc - jobs[0].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nacc;
    int p;
    logic got;
    clear_logs();
    shim_stall = 1'b1; shim_delay = 4; cmp_ready = 1'b1;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      job_src_addr = $urandom; job_dst_addr = $urandom;
      job_length = 30'($urandom_range(1, 4096)); job_id = 8'(i);
      job_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (acc) begin got = 1'b1; break; end
      end
      if (got) nacc++;
    end
    n_tests++; if (nacc !== 5) begin n_fail++; $display("FAIL b2b_accepts got %0d want 5", nacc); end
    n_tests++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_job_ready got %b want 0", job_ready); end
    n_tests++; if (jobs_pending !== 3'd4) begin n_fail++; $display("FAIL b2b_pending got %0d want 4", jobs_pending); end
    shim_stall = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (acc) begin got = 1'b1; break; end
    end
    job_valid = 1'b0;
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_last_accept got %b want 1", got); end
    drain(6, 1000);
    p = 0;
    foreach (jobs[j]) begin
      n_tests++;
      if (j >= cmps.size() || cmps[j].id !== 8'(j) || cmps[j].st !== 2'b00) begin
        n_fail++; $display("FAIL b2b_cmp_order idx=%0d got id=%h st=%b want %h 00",
                           j, (j < cmps.size()) ? cmps[j].id : 8'hxx, (j < cmps.size()) ? cmps[j].st : 2'bxx, 8'(j));
      end
      for (int ph = 0; ph < 2; ph++) begin
        n_tests++;
        if (p >= pulses.size() || pulses[p].dir !== (ph == 0) ||
            pulses[p].addr !== ((ph == 0) ? jobs[j].src : jobs[j].dst) || pulses[p].len !== jobs[j].len) begin
          n_fail++; $display("FAIL b2b_pulse idx=%0d job=%0d phase=%0d got addr=%h want %h",
                             p, j, ph, (p < pulses.size()) ? pulses[p].addr : 32'hx,
                             (ph == 0) ? jobs[j].src : jobs[j].dst);
        end
        p++;
      end
    end
  endtask

  task automatic test_backpressure();
    int np;
    clear_logs();
    shim_delay = 3; cmp_ready = 1'b0;
    send_job(32'h2000_0000, 32'h2100_0000, 30'd64, 8'hA1);
    send_job(32'h2200_0000, 32'h2300_0000, 30'd32, 8'hA2);
    for (int k = 0; k < 200; k++) begin
      if (cmp_valid) break;
      tick();
    end
    n_tests++; if (cmp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_cmp_valid got %b want 1", cmp_valid); end
    np = pulses.size();
    for (int k = 0; k < 50; k++) begin
      tick();
      n_tests++;
      if ({cmp_valid, cmp_id, cmp_status, dma_start_transfer} !== {1'b1, 8'hA1, 2'b00, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d got valid=%b id=%h st=%b start=%b want 1 a1 00 0",
                           k, cmp_valid, cmp_id, cmp_status, dma_start_transfer);
      end
    end
    n_tests++; if (pulses.size() !== np) begin n_fail++; $display("FAIL bp_no_pulse got %0d want %0d", pulses.size(), np); end
    cmp_ready = 1'b1;
    drain(2, 300);
    if (cmps.size() >= 2 && pulses.size() >= 3) begin
      n_tests++;
      if ({cmps[0].id, cmps[1].id} !== {8'hA1, 8'hA2}) begin
        n_fail++; $display("FAIL bp_order got %h %h want a1 a2", cmps[0].id, cmps[1].id);
      end
      n_tests++;
      if (pulses[2].cyc <= cmps[0].cyc) begin
        n_fail++; $display("FAIL bp_next_start got cycle %0d want after %0d", pulses[2].cyc, cmps[0].cyc);
      end
    end
  endtask

  task automatic test_random();
    int sent;
    int p;
    logic [1:0] exp_st;
    clear_logs();
    sent = 0;
    for (int k = 0; k < 8000 && cmps.size() < 24; k++) begin
      cmp_ready  = ($urandom_range(0, 3) != 0);
      shim_delay = $urandom_range(2, 8);
      if (sent < 24 && !job_valid && $urandom_range(0, 1) == 1) begin
        job_src_addr = $urandom; job_dst_addr = $urandom;
        job_length = ($urandom_range(0, 3) == 0) ? 30'd0 : 30'($urandom);
        job_id = 8'($urandom);
        job_valid = 1'b1;
      end
      tick();
      if (acc) begin sent++; job_valid = 1'b0; end
    end
    job_valid = 1'b0; cmp_ready = 1'b1;
    n_tests++; if (cmps.size() !== 24) begin n_fail++; $display("FAIL rand_count got %0d want 24", cmps.size()); end
    p = 0;
    foreach (jobs[j]) begin
      exp_st = (jobs[j].len == 0) ? 2'b10 : 2'b00;
      n_tests++;
      if (j >= cmps.size() || cmps[j].id !== jobs[j].id || cmps[j].st !== exp_st) begin
        n_fail++; $display("FAIL rand_cmp idx=%0d got id=%h st=%b want %h %b",
                           j, (j < cmps.size()) ? cmps[j].id : 8'hxx, (j < cmps.size()) ? cmps[j].st : 2'bxx, jobs[j].id, exp_st);
      end
      if (jobs[j].len != 0) begin
        for (int ph = 0; ph < 2; ph++) begin
          n_tests++;
          if (p >= pulses.size() || pulses[p].dir !== (ph == 0) ||
              pulses[p].addr !== ((ph == 0) ? jobs[j].src : jobs[j].dst) || pulses[p].len !== jobs[j].len) begin
            n_fail++; $display("FAIL rand_pulse idx=%0d job=%0d phase=%0d got addr=%h want %h",
                               p, j, ph, (p < pulses.size()) ? pulses[p].addr : 32'hx,
                               (ph == 0) ? jobs[j].src : jobs[j].dst);
          end
          p++;
        end
      end
    end
    n_tests++; if (pulses.size() !== p) begin n_fail++; $display("FAIL rand_pulse_count got %0d want %0d", pulses.size(), p); end
  endtask

`ifdef DMA_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    shim_stall = 1'b1; shim_delay = 5; cmp_ready = 1'b1;
    send_job(32'h4000_0000, 32'h4100_0000, 30'd128, 8'h77);
    drain(1, 400);
    n_tests++; if (pulses.size() !== 1) begin n_fail++; $display("FAIL to_pulses got %0d want 1", pulses.size()); end
    if (cmps.size() > 0 && pulses.size() > 0) begin
      n_tests++;
      if ({cmps[0].id, cmps[0].st} !== {8'h77, 2'b01}) begin
        n_fail++; $display("FAIL to_cmp got id=%h st=%b want 77 01", cmps[0].id, cmps[0].st);
      end
      n_tests++;
      if (cmps[0].cyc !== pulses[0].cyc + 101) begin
        n_fail++; $display("FAIL to_latency got %0d want 101", cmps[0].cyc - pulses[0].cyc);
      end
    end
    shim_stall = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    n_tests++;
    if (cmps.size() !== 1 || pulses.size() !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_late_done got cmps=%0d pulses=%0d busy=%b want 1 1 0", cmps.size(), pulses.size(), busy);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    clear_logs();
    shim_delay = 10; cmp_ready = 1'b1;
    send_job(32'h5000_0000, 32'h5100_0000, 30'd16, 8'hC1);
    send_job(32'h5200_0000, 32'h5300_0000, 30'd16, 8'hC2);
    send_job(32'h5400_0000, 32'h5500_0000, 30'd16, 8'hC3);
    for (int k = 0; k < 200 && pulses.size() < 2; k++) tick();
    tick(); tick();
    n_tests++; if (jobs_pending !== 3'd2) begin n_fail++; $display("FAIL mid_pending_before got %0d want 2", jobs_pending); end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({job_ready, cmp_valid, cmp_id, cmp_status, dma_start_transfer, dma_direction} !==
        {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset_ctrl got rdy=%b cv=%b id=%h st=%b start=%b dir=%b want 1 0 00 00 0 0",
                         job_ready, cmp_valid, cmp_id, cmp_status, dma_start_transfer, dma_direction);
    end
    n_tests++;
    if ({dma_ddr_addr, dma_length_bytes, busy, jobs_pending} !== {32'h0, 30'h0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL mid_reset_data got addr=%h len=%h busy=%b pend=%0d want 0 0 0 0",
                         dma_ddr_addr, dma_length_bytes, busy, jobs_pending);
    end
    reset = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    n_tests++;
    if (cmps.size() !== 0 || pulses.size() !== 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_flushed got cmps=%0d pulses=%0d busy=%b want 0 2 0", cmps.size(), pulses.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_length();
    test_back_to_back();
    test_backpressure();
    test_random();
`ifdef DMA_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
